// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped full-tag BTB with 2-bit BHT counters.
// Lookups from IF are combinational; EX resolution updates tables and counters.
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic [31:0] NPCPredF,
    output logic        isBtbTakenF,
    output logic        isBhtTakenF,
    input  logic [31:0] PCE,
    input  logic        UpdEnE,
    input  logic        BrTakenE,
    input  logic [31:0] BrTargetE,
    input  logic        isBtbTakenE,
    input  logic        isBhtTakenE,
    output logic        MispredE,
    output logic [31:0] RecoverNPCE,
    output logic [31:0] BrCnt,
    output logic [31:0] MispCnt
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [N-1:0]     valid;
    logic [TAG_W-1:0] tag    [N];
    logic [31:0]      target [N];
    logic [1:0]       bht    [N];

    logic [IDX_W-1:0] idxF, idxE;
    logic [TAG_W-1:0] tagF, tagE;
    logic [31:0]      brcnt_q, mispcnt_q;
    logic             unused_ok;

    assign idxF = PCF[IDX_W+1:2];
    assign tagF = PCF[31:IDX_W+2];
    assign idxE = PCE[IDX_W+1:2];
    assign tagE = PCE[31:IDX_W+2];
    assign unused_ok = ^{PCF[1:0], PCE[1:0]};

    always_comb begin
        isBtbTakenF = valid[idxF] && (tag[idxF] == tagF);
        isBhtTakenF = bht[idxF][1];
        NPCPredF    = PCF + 32'd4;
        if (isBtbTakenF && isBhtTakenF)
            NPCPredF = target[idxF];
    end

    // Full tags make a BTB hit target exact, so only direction can mispredict.
    assign MispredE    = UpdEnE & ((isBtbTakenE & isBhtTakenE) != BrTakenE);
    assign RecoverNPCE = BrTakenE ? BrTargetE : PCE + 32'd4;
    assign BrCnt       = brcnt_q;
    assign MispCnt     = mispcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < N; i++)
                bht[i] <= 2'b01;
        end else if (UpdEnE) begin
            if (BrTakenE) begin
                valid[idxE] <= 1'b1;
                if (bht[idxE] != 2'b11)
                    bht[idxE] <= bht[idxE] + 2'b01;
            end else if (bht[idxE] != 2'b00) begin
                bht[idxE] <= bht[idxE] - 2'b01;
            end
        end
    end

    // Tag/target carry no reset; they are ignored while the entry is invalid.
    always_ff @(posedge clk) begin
        if (!rst && UpdEnE && BrTakenE) begin
            tag[idxE]    <= tagE;
            target[idxE] <= BrTargetE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brcnt_q   <= '0;
            mispcnt_q <= '0;
        end else begin
            if (UpdEnE && brcnt_q != '1)
                brcnt_q <= brcnt_q + 32'd1;
            if (MispredE && mispcnt_q != '1)
                mispcnt_q <= mispcnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int N     = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, BrTargetE;
    logic        UpdEnE, BrTakenE, isBtbTakenE, isBhtTakenE;
    logic [31:0] NPCPredF, RecoverNPCE, BrCnt, MispCnt;
    logic        isBtbTakenF, isBhtTakenF, MispredE;

    int checks   = 0;
    int failures = 0;

    // Model: each entry remembers the whole PC of the last taken branch.
    bit          mv  [N];
    logic [31:0] mpc [N];
    logic [31:0] mtg [N];
    int          mc  [N];
    logic [31:0] mbr, mmi;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .NPCPredF(NPCPredF),
        .isBtbTakenF(isBtbTakenF), .isBhtTakenF(isBhtTakenF),
        .PCE(PCE), .UpdEnE(UpdEnE), .BrTakenE(BrTakenE),
        .BrTargetE(BrTargetE), .isBtbTakenE(isBtbTakenE),
        .isBhtTakenE(isBhtTakenE), .MispredE(MispredE),
        .RecoverNPCE(RecoverNPCE), .BrCnt(BrCnt), .MispCnt(MispCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            mc[i] = 1;
        end
        mbr = 0;
        mmi = 0;
    endtask

    task automatic cyc(input bit r, input logic [31:0] pcf, input bit upd,
                       input bit tk, input logic [31:0] tgt,
                       input logic [31:0] pce, input bit fb, input bit fh);
        int   fi, ei;
        bit   hit, tkn, misp;
        @(negedge clk);
        rst = r; PCF = pcf; UpdEnE = upd; BrTakenE = tk;
        BrTargetE = tgt; PCE = pce; isBtbTakenE = fb; isBhtTakenE = fh;
        #1;
        fi   = ix(pcf);
        hit  = mv[fi] && (mpc[fi][31:2] == pcf[31:2]);
        tkn  = mc[fi] >= 2;
        misp = upd && ((fb && fh) != tk);
        chk("btb_hit", {31'd0, isBtbTakenF}, {31'd0, hit});
        chk("bht_msb", {31'd0, isBhtTakenF}, {31'd0, tkn});
        chk("npc_pred", NPCPredF, (hit && tkn) ? mtg[fi] : pcf + 32'd4);
        chk("mispred", {31'd0, MispredE}, {31'd0, misp});
        if (upd)
            chk("recover_npc", RecoverNPCE, tk ? tgt : pce + 32'd4);
        chk("br_cnt", BrCnt, mbr);
        chk("misp_cnt", MispCnt, mmi);
        if (r) begin
            model_reset();
        end else if (upd) begin
            ei = ix(pce);
            if (mbr != 32'hFFFF_FFFF) mbr++;
            if (misp && mmi != 32'hFFFF_FFFF) mmi++;
            if (tk) begin
                mc[ei]  = (mc[ei] < 3) ? mc[ei] + 1 : 3;
                mv[ei]  = 1'b1;
                mpc[ei] = pce;
                mtg[ei] = tgt;
            end else begin
                mc[ei] = (mc[ei] > 0) ? mc[ei] - 1 : 0;
            end
        end
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        if ($urandom_range(0, 15) == 0)
            p = {$urandom()} & 32'hFFFF_FFFC;
        else
            p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2);
        return p;
    endfunction

    initial begin
        rst = 1'b1; PCF = '0; PCE = '0; BrTargetE = '0;
        UpdEnE = 1'b0; BrTakenE = 1'b0; isBtbTakenE = 1'b0; isBhtTakenE = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            mpc[i] = '0;
            mtg[i] = '0;
        end
        @(posedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Cold lookup
        cyc(0, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("cold_npc", NPCPredF, 32'h44);
        chk("cold_btb", {31'd0, isBtbTakenF}, 32'd0);
        chk("cold_bht", {31'd0, isBhtTakenF}, 32'd0);
        chk("cold_misp", {31'd0, MispredE}, 32'd0);

        // Training, with same-index read-before-write on the first update
        cyc(0, 32'h40, 1, 1, 32'h80, 32'h40, 0, 0);
        chk("rbw_npc", NPCPredF, 32'h44);
        chk("rbw_btb", {31'd0, isBtbTakenF}, 32'd0);
        chk("train_misp", {31'd0, MispredE}, 32'd1);
        chk("train_rec", RecoverNPCE, 32'h80);
        cyc(0, 32'h40, 1, 1, 32'h80, 32'h40, 1, 1);
        chk("rbw_next_btb", {31'd0, isBtbTakenF}, 32'd1);
        chk("train2_misp", {31'd0, MispredE}, 32'd0);
        cyc(0, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("trained_npc", NPCPredF, 32'h80);
        chk("trained_bht", {31'd0, isBhtTakenF}, 32'd1);
        chk("trained_brcnt", BrCnt, 32'd2);
        chk("trained_mispcnt", MispCnt, 32'd1);

        // Hysteresis 11->10->01->00, then a held 00
        cyc(0, 32'h40, 1, 0, 0, 32'h40, 1, 1);
        chk("nt_rec", RecoverNPCE, 32'h44);
        cyc(0, 32'h40, 1, 0, 0, 32'h40, 1, 1);
        chk("ctr10_npc", NPCPredF, 32'h80);
        cyc(0, 32'h40, 1, 0, 0, 32'h40, 1, 0);
        chk("ctr01_npc", NPCPredF, 32'h44);
        chk("ctr01_btb", {31'd0, isBtbTakenF}, 32'd1);
        cyc(0, 32'h40, 1, 0, 0, 32'h40, 1, 0);
        cyc(0, 32'h40, 1, 1, 32'h80, 32'h40, 1, 0);
        cyc(0, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("held00_bht", {31'd0, isBhtTakenF}, 32'd0);

        // Aliasing: 0x440 evicts 0x40 (counter 01 -> 10)
        cyc(0, 32'h40, 1, 1, 32'h100, 32'h440, 0, 0);
        cyc(0, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("alias_old_btb", {31'd0, isBtbTakenF}, 32'd0);
        cyc(0, 32'h440, 0, 0, 0, 0, 0, 0);
        chk("alias_new_btb", {31'd0, isBtbTakenF}, 32'd1);
        chk("alias_new_npc", NPCPredF, 32'h100);

        // PC wrap on fall-through
        cyc(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        chk("wrap_npc", NPCPredF, 32'h0);

        // Reset wins over a simultaneous update
        cyc(1, 32'h80, 1, 1, 32'h200, 32'h80, 0, 0);
        cyc(0, 32'h80, 0, 0, 0, 0, 0, 0);
        chk("rstpri_btb", {31'd0, isBtbTakenF}, 32'd0);
        chk("rstpri_brcnt", BrCnt, 32'd0);
        chk("rstpri_mispcnt", MispCnt, 32'd0);

        // Counter saturation
        dut.brcnt_q   = 32'hFFFF_FFFF;
        dut.mispcnt_q = 32'hFFFF_FFFF;
        mbr = 32'hFFFF_FFFF;
        mmi = 32'hFFFF_FFFF;
        cyc(0, 32'h80, 1, 1, 32'h200, 32'h80, 0, 0);
        cyc(0, 32'h80, 0, 0, 0, 0, 0, 0);
        chk("sat_brcnt", BrCnt, 32'hFFFF_FFFF);
        chk("sat_mispcnt", MispCnt, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 49) == 0, rpc(), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, {$urandom()} & 32'hFFFF_FFFC,
                rpc(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, giving the index width; the tables hold 2^IDX_W entries.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port PCF, input, 32 bits: the IF-stage PC used for lookup.
REQ-005 SHALL have port NPCPredF, output, 32 bits: the predicted next PC for IF.
REQ-006 SHALL have port isBtbTakenF, output, 1 bit: BTB hit for PCF.
REQ-007 SHALL have port isBhtTakenF, output, 1 bit: the BHT counter MSB for PCF.
REQ-008 SHALL have port PCE, input, 32 bits: the PC of the branch in EX.
REQ-009 SHALL have port UpdEnE, input, 1 bit: a valid, unflushed conditional branch resolved in EX this cycle.
REQ-010 SHALL have port BrTakenE, input, 1 bit: the actual branch outcome.
REQ-011 SHALL have port BrTargetE, input, 32 bits: the actual branch target.
REQ-012 SHALL have ports isBtbTakenE and isBhtTakenE, input, 1 bit each: the prediction flags carried through the ID/EX register.
REQ-013 SHALL have port MispredE, output, 1 bit: misprediction detected, so flush IF/ID and redirect.
REQ-014 SHALL have port RecoverNPCE, output, 32 bits: the correct next PC after the EX branch.
REQ-015 SHALL have port BrCnt, output, 32 bits: count of resolved branches.
REQ-016 SHALL have port MispCnt, output, 32 bits: count of mispredictions.

Function
REQ-017 SHALL decode lookup fields as idxF = PCF[IDX_W+1:2] and tagF = PCF[31:IDX_W+2]; update fields idxE/tagE SHALL be decoded identically from PCE.
REQ-018 SHALL hold per entry a BTB valid bit, a BTB tag of 30-IDX_W bits, a 32-bit BTB target, and a 2-bit BHT counter.
REQ-019 SHALL drive isBtbTakenF combinationally as valid[idxF] & (tag[idxF]==tagF), with zero latency.
REQ-020 SHALL drive isBhtTakenF combinationally as bht[idxF][1].
REQ-021 SHALL drive NPCPredF as target[idxF] when isBtbTakenF & isBhtTakenF, otherwise PCF+4 (mod 2^32, wrap permitted).
REQ-022 SHALL, on a clock edge with UpdEnE=1 and BrTakenE=1, saturate-increment bht[idxE] (3 stays 3) and write valid=1, tag=tagE, target=BrTargetE into BTB entry idxE, overwriting any aliasing entry.
REQ-023 SHALL, on a clock edge with UpdEnE=1 and BrTakenE=0, saturate-decrement bht[idxE] (0 stays 0) and leave the BTB entry unchanged.
REQ-024 SHALL leave all tables and counters unchanged when UpdEnE=0.
REQ-025 SHALL give read-before-write behaviour when idxF==idxE in an update cycle: lookup outputs reflect pre-update contents in that cycle and new contents from the next cycle.
REQ-026 SHALL drive MispredE combinationally as UpdEnE & ((isBtbTakenE & isBhtTakenE) != BrTakenE); there is no target-mismatch term, because full tags and PC-relative targets make a hit target exact.
REQ-027 SHALL drive RecoverNPCE as BrTargetE when BrTakenE=1, otherwise PCE+4; it is valid whenever UpdEnE=1 and don't-care otherwise.
REQ-028 SHALL increment BrCnt by 1 on each edge with UpdEnE=1, and SHALL increment MispCnt by 1 on each edge with MispredE=1.
REQ-029 SHALL saturate BrCnt and MispCnt at 32'hFFFFFFFF with no wrap.
REQ-030 SHALL keep the predictor stall-agnostic; the hazard unit deasserts UpdEnE for stalled or flushed EX slots.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear all BTB valid bits, set every BHT counter to 2'b01 (weakly not-taken), and zero BrCnt and MispCnt.
REQ-032 SHALL let reset take priority over a simultaneous UpdEnE=1, so that no update or count occurs in that cycle.
REQ-033 SHALL produce, after reset, isBtbTakenF=0, isBhtTakenF=0, NPCPredF=PCF+4 and MispredE=0 (with UpdEnE=0); BTB tag/target contents are don't-care while invalid.
REQ-034 SHALL accept reset mid-operation: an update in progress is discarded, and the state after the edge equals the power-on reset state.

Verification
REQ-035 SHALL cover cold lookup: after reset, PCF=0x40 -> NPCPredF=0x44, isBtbTakenF=0, isBhtTakenF=0.
REQ-036 SHALL cover training: two taken updates at PCE=0x40 with BrTargetE=0x80 (counter 01->10->11) -> PCF=0x40 gives isBtbTakenF=1, isBhtTakenF=1, NPCPredF=0x80; the first update cycle shows MispredE=1 with flags 0/0, and BrCnt=2, MispCnt=1.
REQ-037 SHALL cover saturation and hysteresis: counter at 11 plus three not-taken updates -> 10, 01, 00, with a further not-taken holding 00; NPCPredF=0x44 once the MSB=0 while isBtbTakenF stays 1.
REQ-038 SHALL cover aliasing: a taken update at PCE=0x440 (same index as 0x40, IDX_W=4) -> PCF=0x40 now gives isBtbTakenF=0 and PCF=0x440 gives isBtbTakenF=1.
REQ-039 SHALL cover same-index read/write: PCF=PCE=0x40 with UpdEnE=1 taken from the cold state -> outputs that cycle are unchanged (NPCPredF=0x44), and isBtbTakenF=1 on the next cycle.
REQ-040 SHALL cover reset priority and counter saturation: rst=1 together with UpdEnE=1 -> counters 0 and the entry remains invalid; forcing BrCnt=0xFFFFFFFF plus an update -> BrCnt stays 0xFFFFFFFF.
